// File: rtl/reg_32_secuenciador_pkg.sv
// Shared types and codes for the reg_32 command sequencer: command ops,
// register MODO codes, FSM state encoding and the latched command payload.
package reg_32_secuenciador_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned STATS_W = 16;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SHIFT  = 2'b01,
    OP_ROT    = 2'b10,
    OP_LSHIFT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MODO_SHIFT = 2'b00,
    MODO_ROT   = 2'b01,
    MODO_LOAD  = 2'b10
  } modo_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  typedef struct packed {
    op_e               op;
    logic              dir;
    logic              sin;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // Effective shift count: requests above max_cnt are clamped
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] cnt,
                                                 input int unsigned max_cnt);
    return (32'(cnt) > max_cnt) ? CNT_W'(max_cnt) : cnt;
  endfunction

endpackage

// File: rtl/reg_32_sec_contador.sv
// Loadable down-counter sequencing the SHIFT phase; last flags the final cycle.
module reg_32_sec_contador
  import reg_32_secuenciador_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/reg_32_secuenciador.sv
// Command-driven controller for the 32-bit shift register: load/shift/rotate
// sequencing plus result capture. REG32_SEQ_STATS_EN adds the SHIFT_TOTAL counter.
module reg_32_secuenciador
  import reg_32_secuenciador_pkg::*;
#(
  parameter int unsigned MAX_CNT = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_OP,
  input  logic              CMD_DIR,
  input  logic [CNT_W-1:0]  CMD_CNT,
  input  logic              CMD_SIN,
  input  logic [DATA_W-1:0] CMD_DATA,
  output logic              ENB,
  output logic              DIR,
  output logic [1:0]        MODO,
  output logic              S_IN,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [DATA_W-1:0] RES_DATA
`ifdef REG32_SEQ_STATS_EN
  ,
  output logic [STATS_W-1:0] SHIFT_TOTAL
`endif
);

  state_e            state, state_next;
  cmd_t              cmd_q, cmd_in, cmd_cur;
  logic              accept;
  logic [CNT_W-1:0]  n_eff, cnt;
  logic              cnt_last, cnt_load, cnt_dec;
  logic              enb_d, dir_d, sin_d;
  modo_e             modo_d;
  logic [DATA_W-1:0] d_d;

  assign cmd_in    = '{op: op_e'(CMD_OP), dir: CMD_DIR, sin: CMD_SIN, data: CMD_DATA};
  assign accept    = (state == ST_IDLE) && CMD_VALID;
  assign cmd_cur   = accept ? cmd_in : cmd_q;
  assign n_eff     = clamp_cnt(CMD_CNT, MAX_CNT);
  assign CMD_READY = (state == ST_IDLE) && !RST;

  reg_32_sec_contador u_contador (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (n_eff),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state, then register-drive values decoded from the state being entered
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    enb_d      = 1'b0;
    modo_d     = MODO_SHIFT;
    dir_d      = 1'b0;
    sin_d      = 1'b0;
    d_d        = '0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          if ((cmd_in.op == OP_LOAD) || (cmd_in.op == OP_LSHIFT)) state_next = ST_LOAD;
          else if (n_eff != '0)                                 state_next = ST_SHIFT;
          else                                                  state_next = ST_CAPTURE;
        end
      end
      ST_LOAD: begin
        if ((cmd_q.op == OP_LSHIFT) && (cnt != '0)) state_next = ST_SHIFT;
        else                                        state_next = ST_CAPTURE;
      end
      ST_SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt_last) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: state_next = ST_RESP;
      ST_RESP:    if (RES_READY) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase

    case (state_next)
      ST_LOAD: begin
        enb_d  = 1'b1;
        modo_d = MODO_LOAD;
        d_d    = cmd_cur.data;
      end
      ST_SHIFT: begin
        enb_d  = 1'b1;
        modo_d = (cmd_cur.op == OP_ROT) ? MODO_ROT : MODO_SHIFT;
        dir_d  = cmd_cur.dir;
        sin_d  = cmd_cur.sin;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cmd_q     <= '0;
      ENB       <= 1'b0;
      DIR       <= 1'b0;
      MODO      <= 2'(MODO_SHIFT);
      S_IN      <= 1'b0;
      D         <= '0;
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
    end else begin
      if (accept) cmd_q <= cmd_in;
      ENB       <= enb_d;
      DIR       <= dir_d;
      MODO      <= 2'(modo_d);
      S_IN      <= sin_d;
      D         <= d_d;
      RES_VALID <= (state_next == ST_RESP);
      if (state == ST_CAPTURE) RES_DATA <= Q;
    end
  end

`ifdef REG32_SEQ_STATS_EN
  logic [STATS_W-1:0] shift_total;

  // Saturating count of shift/rotate enable cycles
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_total <= '0;
    end else if (ENB && (MODO != 2'(MODO_LOAD)) && (shift_total != {STATS_W{1'b1}})) begin
      shift_total <= shift_total + STATS_W'(1);
    end
  end

  assign SHIFT_TOTAL = shift_total;
`endif

endmodule
